// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop input synchronizer and a small receive FIFO.
// Define UART_RX_PARITY_EN to add one even-parity bit between data and stop.
module uart_rx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 921600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic       busy
);

  localparam int DATA_W  = 8;
  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int HALF    = BIT_CYC / 2;
  localparam int CNT_W   = $clog2(BIT_CYC + 1);
  localparam int AW      = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF - 1);
  localparam logic [AW:0]      OCC_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

`ifdef UART_RX_PARITY_EN
  function automatic logic even_parity_ok(input logic [DATA_W-1:0] d, input logic p);
    return ~(^d ^ p);
  endfunction
`endif

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [2:0]        idx, idx_nxt;
  logic              sync_p0, sync_p1, rxs, rxs_d;
  logic [DATA_W-1:0] shreg;
  logic              sample_bit, push_req, fe_nxt;
`ifdef UART_RX_PARITY_EN
  logic              pbit, pbit_ld, pe_nxt;
`endif

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       occ;
  logic              full, pop, do_push, ovr_nxt;

  assign rxs  = sync_p1;
  assign busy = (state != IDLE);

  // Synchronizer, edge history and FSM control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      rxs_d   <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
    end else begin
      sync_p0 <= rxd_in;
      sync_p1 <= sync_p0;
      rxs_d   <= rxs;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + 1'b1;
    idx_nxt    = idx;
    sample_bit = 1'b0;
    push_req   = 1'b0;
    fe_nxt     = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbit_ld    = 1'b0;
    pe_nxt     = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (rxs_d && !rxs) state_nxt = START;
      end
      START: begin
        if (cnt == HALF_END) begin
          cnt_nxt = '0;
          idx_nxt = '0;
          state_nxt = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_END) begin
          cnt_nxt    = '0;
          sample_bit = 1'b1;
          idx_nxt    = idx + 3'd1;
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == BIT_END) begin
          cnt_nxt   = '0;
          pbit_ld   = 1'b1;
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == BIT_END) begin
          cnt_nxt = '0;
          if (rxs) begin
            state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
            if (even_parity_ok(shreg, pbit)) push_req = 1'b1;
            else                             pe_nxt   = 1'b1;
`else
            push_req = 1'b1;
`endif
          end else begin
            fe_nxt    = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_nxt = '0;
        if (rxs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Receive FIFO: push from the stop-bit decision, pop from the consumer
  assign full     = (occ == OCC_FULL);
  assign rx_valid = (occ != '0);
  assign pop      = rx_valid & rx_ready;
  assign do_push  = push_req & (~full | pop);
  assign ovr_nxt  = push_req & full & ~pop;
  assign rx_data  = rx_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (sample_bit) shreg[idx] <= rxs;
`ifdef UART_RX_PARITY_EN
    if (pbit_ld) pbit <= rxs;
`endif
    if (do_push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      frame_err <= fe_nxt;
      overrun   <= ovr_nxt;
`ifdef UART_RX_PARITY_EN
      parity_err <= pe_nxt;
`else
      parity_err <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at default parameters (54 clocks per bit).
module tb_uart_rx;

  localparam int BIT = 54;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       frame_err, overrun, parity_err, busy;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  logic [7:0] exp_q[$];

  uart_rx dut (
    .clk(clk), .rst_n(rst_n), .rxd_in(rxd_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err),
    .busy(busy)
  );

  always #10 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each accepted byte, tracks pulses and head stability
  logic fe_prev = 1'b0, ov_prev = 1'b0, pe_prev = 1'b0;
  logic hold_prev = 1'b0;
  logic [7:0] hold_data = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) chk(1'b0, "unexpected_byte", {24'd0, rx_data}, 32'hFFFF_FFFF);
        else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk(rx_data == e, "rx_byte", {24'd0, rx_data}, {24'd0, e});
        end
      end
      if (hold_prev && rx_valid)
        chk(rx_data == hold_data, "head_stable", {24'd0, rx_data}, {24'd0, hold_data});
      if (frame_err) begin fe_cnt++; chk(!fe_prev, "frame_err_1cyc", 32'(fe_prev), 0); end
      if (overrun)   begin ov_cnt++; chk(!ov_prev, "overrun_1cyc", 32'(ov_prev), 0); end
      if (parity_err) begin pe_cnt++; chk(!pe_prev, "parity_err_1cyc", 32'(pe_prev), 0); end
    end
    fe_prev   = frame_err;
    ov_prev   = overrun;
    pe_prev   = parity_err;
    hold_prev = rst_n && rx_valid && !rx_ready;
    hold_data = rx_data;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(posedge clk); #1 rxd_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (BIT) @(posedge clk); #1 rxd_in = b[i];
    end
    repeat (BIT) @(posedge clk); #1 rxd_in = stop_bit;
    repeat (BIT) @(posedge clk);
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (rx_valid && n < 60) begin @(posedge clk); #1; n++; end
    chk(!rx_valid, name, 32'(rx_valid), 0);
  endtask

  task automatic check_outputs_zero(input string name);
    logic [13:0] v;
    v = {rx_valid, rx_data, frame_err, overrun, parity_err, busy, 1'b0};
    chk(v == '0, name, {18'd0, v}, 0);
  endtask

  initial begin
    int fe0, ov0;

    // Reset state
    repeat (3) @(posedge clk);
    #2 check_outputs_zero("reset_outputs");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // 0x55: exact push latency, then drain
    fe0 = fe_cnt; ov0 = ov_cnt;
    exp_q.push_back(8'h55);
    fork
      send_byte(8'h55, 1'b1);
      begin
        @(posedge clk);
        repeat (515) @(posedge clk);
        #1 chk(!rx_valid, "latency_before_push", 32'(rx_valid), 0);
        @(posedge clk);
        #1 chk(rx_valid && rx_data == 8'h55, "latency_push_55", {23'd0, rx_valid, rx_data}, 32'h155);
      end
    join
    chk(fe_cnt == fe0 && ov_cnt == ov0, "no_err_55", 32'(fe_cnt + ov_cnt), 32'(fe0 + ov0));
    #1 rx_ready = 1'b1;
    wait_empty("drain_55");
    @(posedge clk); #1 rx_ready = 1'b0;

    // 0xA3, 0x0F back-to-back held in FIFO, then drained on consecutive cycles
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0F);
    send_byte(8'hA3, 1'b1);
    send_byte(8'h0F, 1'b1);
    repeat (3) @(posedge clk);
    #1 rx_ready = 1'b1;
    @(negedge clk) chk(rx_valid && rx_data == 8'hA3, "drain_first_A3", {23'd0, rx_valid, rx_data}, 32'h1A3);
    @(negedge clk) chk(rx_valid && rx_data == 8'h0F, "drain_second_0F", {23'd0, rx_valid, rx_data}, 32'h10F);
    @(negedge clk) chk(!rx_valid, "drain_done", 32'(rx_valid), 0);
    @(posedge clk); #1 rx_ready = 1'b0;

    // 10-cycle glitch must be rejected silently
    fe0 = fe_cnt; ov0 = ov_cnt;
    @(posedge clk); #1 rxd_in = 1'b0;
    repeat (10) @(posedge clk);
    #1 rxd_in = 1'b1;
    chk(busy, "glitch_busy_asserted", 32'(busy), 1);
    begin
      int n;
      n = 0;
      while (busy && n < 28) begin @(posedge clk); #1; n++; end
      chk(!busy, "glitch_busy_release", 32'(n), 28);
    end
    repeat (BIT) @(posedge clk);
    chk(!rx_valid && fe_cnt == fe0 && ov_cnt == ov0, "glitch_no_push",
        {rx_valid, 31'(fe_cnt + ov_cnt)}, 32'(fe0 + ov0));

    // 0x81 with low stop bit and 3 bit times of break, then 0x42
    fe0 = fe_cnt;
    send_byte(8'h81, 1'b0);
    repeat (2 * BIT) @(posedge clk);
    #1 rxd_in = 1'b1;
    repeat (BIT) @(posedge clk);
    chk(fe_cnt == fe0 + 1, "break_one_frame_err", 32'(fe_cnt - fe0), 1);
    chk(!rx_valid && !busy, "break_no_push", {30'd0, rx_valid, busy}, 0);
    rx_ready = 1'b1;
    exp_q.push_back(8'h42);
    send_byte(8'h42, 1'b1);
    wait_empty("drain_42");
    chk(fe_cnt == fe0 + 1, "after_break_no_err", 32'(fe_cnt - fe0), 1);
    @(posedge clk); #1 rx_ready = 1'b0;

    // Overrun: 9 bytes into an 8-entry FIFO
    ov0 = ov_cnt;
    for (int b = 0; b < 8; b++) begin
      exp_q.push_back(8'(b));
      send_byte(8'(b), 1'b1);
    end
    chk(ov_cnt == ov0, "no_overrun_first8", 32'(ov_cnt - ov0), 0);
    send_byte(8'h08, 1'b1);
    chk(ov_cnt == ov0 + 1, "overrun_on_byte8", 32'(ov_cnt - ov0), 1);
    #1 rx_ready = 1'b1;
    wait_empty("drain_overrun");
    @(posedge clk); #1 rx_ready = 1'b0;

    // Reset mid-frame flushes FIFO and abandons the frame
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_byte(8'h99, 1'b1);
    chk(rx_valid && rx_data == 8'h99, "prefill_99", {23'd0, rx_valid, rx_data}, 32'h199);
    fork
      send_byte(8'hFF, 1'b1);
      begin
        repeat (200) @(posedge clk);
        #1 chk(busy, "busy_mid_frame", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #2 check_outputs_zero("async_reset_outputs");
        repeat (4) @(negedge clk);
        check_outputs_zero("held_reset_outputs");
        @(posedge clk); #1 rst_n = 1'b1;
      end
    join
    repeat (20) @(posedge clk);
    chk(!rx_valid && !busy && fe_cnt == fe0 && ov_cnt == ov0, "post_reset_idle",
        {rx_valid, busy, 30'(fe_cnt + ov_cnt)}, 32'(fe0 + ov0));
    rx_ready = 1'b1;
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    wait_empty("drain_3C");

    repeat (10) @(posedge clk);
    chk(exp_q.size() == 0, "scoreboard_empty", 32'(exp_q.size()), 0);
    chk(pe_cnt == 0, "parity_err_tied", 32'(pe_cnt), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
